// File: rtl/setting_bus_arbiter_pkg.sv
// Shared constants and entry type for the setting-bus write merger.
package setting_bus_arbiter_pkg;
    localparam int SETTING_AW = 7;
    localparam int SETTING_DW = 32;

    localparam logic SRC_DB = 1'b0;
    localparam logic SRC_WR = 1'b1;

    typedef struct packed {
        logic [SETTING_AW-1:0] addr;
        logic [SETTING_DW-1:0] data;
    } setting_entry_t;
endpackage

// File: rtl/setting_bus_arbiter_if.sv
// One setting-bus write stream: strobe plus address and data.
interface setting_bus_arbiter_if
    import setting_bus_arbiter_pkg::*;
#(
    parameter int AW = SETTING_AW,
    parameter int DW = SETTING_DW
) ();
    logic          strobe;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    modport master (output strobe, addr, data);
    modport slave  (input  strobe, addr, data);
endinterface

// File: rtl/setting_bus_arbiter_fifo.sv
// Small synchronous FIFO with a combinational head entry.
module setting_fifo
    import setting_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SETTING_AW + SETTING_DW
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
endmodule

// File: rtl/setting_bus_arbiter.sv
// Merges SPI and in-band setting writes into one stream,
// queueing each source and draining round-robin.
module setting_bus_arbiter
    import setting_bus_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SETTING_AW,
    parameter int DW    = SETTING_DW
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_status,
    setting_bus_arbiter_if.slave  db,
    setting_bus_arbiter_if.slave  wr,
    setting_bus_arbiter_if.master serial,
    output logic [1:0]            overflow,
    output logic                  busy
);
    localparam int EW = AW + DW;

    logic          full_db, full_wr;
    logic          empty_db, empty_wr;
    logic [EW-1:0] head_db, head_wr;
    logic          grant_db, grant_wr;
    logic          push_db, push_wr;
    logic          drop_db, drop_wr;
    logic          last_grant;

    always_comb begin
        grant_db = !empty_db && (empty_wr || last_grant == SRC_WR);
        grant_wr = !empty_wr && (empty_db || last_grant == SRC_DB);
    end

    // A full FIFO still accepts when it is being drained this edge.
    assign push_db = db.strobe && (!full_db || grant_db);
    assign push_wr = wr.strobe && (!full_wr || grant_wr);
    assign drop_db = db.strobe && full_db && !grant_db;
    assign drop_wr = wr.strobe && full_wr && !grant_wr;

    setting_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_db (
        .clock (clock),
        .reset (reset),
        .push  (push_db),
        .pop   (grant_db),
        .din   ({db.addr, db.data}),
        .head  (head_db),
        .full  (full_db),
        .empty (empty_db)
    );

    setting_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo_wr (
        .clock (clock),
        .reset (reset),
        .push  (push_wr),
        .pop   (grant_wr),
        .din   ({wr.addr, wr.data}),
        .head  (head_wr),
        .full  (full_wr),
        .empty (empty_wr)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            serial.strobe <= 1'b0;
            serial.addr   <= '0;
            serial.data   <= '0;
            overflow      <= '0;
            last_grant    <= SRC_WR;
        end else begin
            serial.strobe <= grant_db || grant_wr;
            unique case (1'b1)
                grant_db: begin
                    {serial.addr, serial.data} <= head_db;
                    last_grant <= SRC_DB;
                end
                grant_wr: begin
                    {serial.addr, serial.data} <= head_wr;
                    last_grant <= SRC_WR;
                end
                default: ;
            endcase
            // A drop on the clearing edge keeps its flag.
            overflow <= (overflow & ~{2{clear_status}})
                      | {drop_wr, drop_db};
        end
    end

    assign busy = !empty_db || !empty_wr || serial.strobe;
endmodule

// File: tb/tb_setting_bus_arbiter.sv
// Directed bench for the setting-bus write merger.
module tb_setting_bus_arbiter;
    import setting_bus_arbiter_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       clear_status;
    logic [1:0] overflow;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    setting_bus_arbiter_if #(.AW(SETTING_AW), .DW(SETTING_DW)) db ();
    setting_bus_arbiter_if #(.AW(SETTING_AW), .DW(SETTING_DW)) wr ();
    setting_bus_arbiter_if #(.AW(SETTING_AW), .DW(SETTING_DW)) serial ();

    setting_bus_arbiter #(.DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .clear_status (clear_status),
        .db           (db),
        .wr           (wr),
        .serial       (serial),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] da(int i);
        return 7'(32 + i);
    endfunction
    function automatic logic [31:0] dd(int i);
        return 32'hD000_0000 | 32'(i);
    endfunction
    function automatic logic [6:0] wa(int i);
        return 7'(64 + i);
    endfunction
    function automatic logic [31:0] wd(int i);
        return 32'hE000_0000 | 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag,
                        input bit ds, input int di,
                        input bit ws, input int wi,
                        input bit clr,
                        input bit es, input logic [6:0] ea,
                        input logic [31:0] ed, input logic [1:0] eo);
        db.strobe    = ds;
        db.addr      = da(di);
        db.data      = dd(di);
        wr.strobe    = ws;
        wr.addr      = wa(wi);
        wr.data      = wd(wi);
        clear_status = clr;
        tick();
        chk({tag, ".stb"}, 64'(serial.strobe), 64'(es));
        if (es) begin
            chk({tag, ".addr"}, 64'(serial.addr), 64'(ea));
            chk({tag, ".data"}, 64'(serial.data), 64'(ed));
        end
        chk({tag, ".ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        logic       es;
        logic [6:0] ea;
        logic [31:0] ed;
        logic [1:0] eo;

        reset        = 1'b1;
        clear_status = 1'b0;
        db.strobe    = 1'b0;
        db.addr      = '0;
        db.data      = '0;
        wr.strobe    = 1'b0;
        wr.addr      = '0;
        wr.data      = '0;
        #12;
        chk("rst.stb",  64'(serial.strobe), 64'(0));
        chk("rst.addr", 64'(serial.addr),   64'(0));
        chk("rst.data", 64'(serial.data),   64'(0));
        chk("rst.ovf",  64'(overflow),      64'(0));
        chk("rst.busy", 64'(busy),          64'(0));
        @(negedge clock);
        reset = 1'b0;

        // collision: SPI wins the first tie after reset
        step("col0", 1, 0, 1, 0, 0, 0, 7'h0, 32'h0, 2'b00);
        step("col1", 0, 0, 0, 0, 0, 1, da(0), dd(0), 2'b00);
        step("col2", 0, 0, 0, 0, 0, 1, wa(0), wd(0), 2'b00);
        step("col3", 0, 0, 0, 0, 0, 0, 7'h0, 32'h0, 2'b00);
        chk("col.busy", 64'(busy), 64'(0));

        // single write, two-cycle latency
        db.strobe = 1'b1;
        db.addr   = 7'h20;
        db.data   = 32'h1234_5678;
        tick();
        chk("one.stb0",  64'(serial.strobe), 64'(0));
        chk("one.busy0", 64'(busy),          64'(1));
        db.strobe = 1'b0;
        tick();
        chk("one.stb1",  64'(serial.strobe), 64'(1));
        chk("one.addr",  64'(serial.addr),   64'(7'h20));
        chk("one.data",  64'(serial.data),   64'(32'h1234_5678));
        tick();
        chk("one.stb2",  64'(serial.strobe), 64'(0));
        chk("one.busy2", 64'(busy),          64'(0));

        // burst: 8 in-band writes, one SPI write at edge 3
        for (int e = 0; e < 11; e++) begin
            es = (e >= 1 && e <= 9);
            if (e == 4) begin
                ea = da(0);
                ed = dd(0);
            end else if (e < 4) begin
                ea = wa(e - 1);
                ed = wd(e - 1);
            end else begin
                ea = wa(e - 2);
                ed = wd(e - 2);
            end
            step($sformatf("burst%0d", e), e == 3, 0, e < 8, e, 0,
                 es, ea, ed, 2'b00);
        end
        chk("burst.busy", 64'(busy), 64'(0));

        // reset with three entries queued
        step("rm0", 1, 1, 1, 1, 0, 0, 7'h0, 32'h0, 2'b00);
        step("rm1", 1, 2, 1, 2, 0, 1, da(1), dd(1), 2'b00);
        db.strobe = 1'b0;
        wr.strobe = 1'b0;
        chk("rm.busy", 64'(busy), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk("rm.stb",  64'(serial.strobe), 64'(0));
        chk("rm.addr", 64'(serial.addr),   64'(0));
        chk("rm.data", 64'(serial.data),   64'(0));
        chk("rm.bsy",  64'(busy),          64'(0));
        @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step($sformatf("rmidle%0d", e), 0, 0, 0, 0, 0,
                 0, 7'h0, 32'h0, 2'b00);
            chk($sformatf("rmidle%0d.busy", e), 64'(busy), 64'(0));
        end

        // overflow, full-with-pop at edge 6, clear vs drop at edge 9
        for (int e = 0; e < 18; e++) begin
            es = (e >= 1 && e <= 16);
            if (e == 16) begin
                ea = wa(8);
                ed = wd(8);
            end else if (e % 2 == 1) begin
                ea = da((e - 1) / 2);
                ed = dd((e - 1) / 2);
            end else begin
                ea = wa((e - 2) / 2);
                ed = wd((e - 2) / 2);
            end
            eo = (e >= 7 && e <= 9) ? 2'b10 : 2'b00;
            step($sformatf("ovf%0d", e), e <= 7, e, e <= 9, e,
                 (e == 9 || e == 10), es, ea, ed, eo);
        end
        chk("ovf.busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
